imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory: fills the 16-word instruction store from a byte-serial source before the pipeline runs.
- Assembles bytes into big-endian 32-bit MIPS instruction words and issues one-cycle write strobes at sequential word addresses.
- Asserts cpu_stall while loading so fetch does not read a partially written store.
- Sits between the host/boot byte source and the instruction memory write port.

Parameters:
- DEPTH, 16, number of 32-bit words in the instruction store.
- ADDR_W, 4, word address width; DEPTH must equal 2**ADDR_W.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load from word 0. Honoured only in IDLE or DONE.
- in_byte  input  8  next program byte, most-significant byte of each word first.
- in_valid  input  1  in_byte is valid.
- in_last  input  1  qualifies in_byte as the final byte of the program; sampled only on handshake.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  one-cycle instruction memory write strobe.
- wr_addr  output  ADDR_W  word address for wr_data.
- wr_data  output  32  assembled instruction word.
- busy  output  1  high in LOAD and WRITE.
- done  output  1  high in DONE.
- cpu_stall  output  1  equals busy.
- word_count  output  ADDR_W+1  number of words written in the current or last load (0..DEPTH).
- checksum  output  8  running XOR of accepted bytes; see Optional Feature.

Behaviour:
- Reset (rst_n=0 at a clock edge) applies regardless of state, including mid-load:
  - state=IDLE; all outputs 0.
  - Internal byte index and assembly register cleared.
  - The memory image is not cleared.
- Byte handshake: a byte is accepted on a clock edge when in_valid=1 and in_ready=1. in_ready=1 only in LOAD.
- States:
  - IDLE: on start -> LOAD; word_count, byte index, address and checksum cleared.
  - LOAD: each accepted byte is shifted into the assembly register at byte lane 3-idx: lane 3 is bits [31:24] and is the first byte.
    - If the byte completes a word (idx=3) or in_last=1 -> WRITE.
    - When in_last ends a partial word, unfilled lower lanes are 0.
  - WRITE: exactly one cycle; in_ready=0.
    - wr_en=1, wr_addr=current address, wr_data=assembled word.
    - On the next edge: word_count+1, address+1 (wraps at DEPTH-1), byte index cleared.
    - Next state is DONE if the last byte carried in_last or word_count+1==DEPTH; otherwise LOAD.
  - DONE: done=1 held; in_ready=0. start -> LOAD with counters cleared as in IDLE.
- Latency: write strobe occurs in the cycle after the 4th (or last) byte is accepted.
  - Back-to-back bytes give a sustained rate of 4 bytes per 5 cycles.
- wr_en is never high outside WRITE. wr_addr and wr_data hold their last values when wr_en=0.
- start during LOAD or WRITE is ignored.
- in_last on a word-completing byte yields a single write, with no padded extra word.
- Bytes offered after DEPTH words are written are not accepted: in_ready=0 in DONE.
- word_count saturates at DEPTH; the wr_addr wrap to 0 never produces a write in the same load.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined: checksum is cleared on start. On each accepted byte, checksum <= checksum ^ in_byte. It is held through DONE until the next start or reset.
- Undefined: checksum is tied to 8'h00; no checksum register is synthesised.

Test Plan:
- Reset, then start, then bytes 20,08,00,05 -> in the cycle after the 4th byte: wr_en=1, wr_addr=0, wr_data=32'h20080005; word_count=1.
- 64 back-to-back bytes -> 16 writes at addresses 0..15; done=1; cpu_stall=0 after the 16th write; in_ready stays 0 with in_valid held high.
- Bytes AC,09 with in_last on 09 -> single write wr_data=32'hAC090000; DONE with word_count=1.
- Gaps in in_valid mid-word, plus start pulsed during LOAD -> same wr_data as the gapless case; start has no effect.
- rst_n=0 after 2 words plus 2 bytes -> next cycle IDLE with all outputs 0. A following start rewrites from wr_addr=0.
- With IMEM_LOADER_CHECKSUM_EN: bytes 01,02,04,08 -> checksum=8'h0F. Without the macro: checksum=8'h00.

Source files
------------

// File: rtl/imem_loader.sv
// Byte-serial instruction memory loader: packs big-endian bytes into 32-bit words and writes them at sequential addresses.
// Optional running XOR checksum of accepted bytes is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              cpu_stall,
  output logic [ADDR_W:0]   word_count,
  output logic [7:0]        checksum,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

  state_t              state, state_nx;
  logic [1:0]          idx;
  logic [31:0]         asm_q;
  logic [31:0]         word_nx;
  logic [4:0]          shamt;
  logic [ADDR_W-1:0]   addr_q;
  logic                last_q;
  logic                accept;
  logic                restart;

  // Handshake: a byte transfers on a rising edge where in_valid and in_ready are both high;
  // in_ready depends only on state, never on in_valid.
  always_comb begin
    in_ready = (state == S_LOAD);
    accept   = in_valid && in_ready;
    restart  = start && ((state == S_IDLE) || (state == S_DONE));
    shamt    = {2'd3 - idx, 3'b000};
    word_nx  = asm_q | ({24'h0, in_byte} << shamt);
    wr_en    = (state == S_WRITE);
    busy     = (state == S_LOAD) || (state == S_WRITE);
    done     = (state == S_DONE);
    cpu_stall = busy;
    fsm_state = state;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  if (accept && ((idx == 2'd3) || in_last)) state_nx = S_WRITE;
      S_WRITE: state_nx = (last_q || (word_count == LAST_CNT)) ? S_DONE : S_LOAD;
      S_DONE:  if (start) state_nx = S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      asm_q      <= '0;
      addr_q     <= '0;
      last_q     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      word_count <= '0;
    end else begin
      state <= state_nx;
      if (restart) begin
        idx        <= '0;
        asm_q      <= '0;
        addr_q     <= '0;
        last_q     <= 1'b0;
        word_count <= '0;
      end
      if (accept) begin
        // The word-closing byte goes straight to the write port; the assembly register restarts empty.
        if ((idx == 2'd3) || in_last) begin
          wr_data <= word_nx;
          wr_addr <= addr_q;
          asm_q   <= '0;
          last_q  <= in_last;
        end else begin
          asm_q <= word_nx;
          idx   <= idx + 2'd1;
        end
      end
      if (state == S_WRITE) begin
        word_count <= word_count + 1'b1;
        addr_q     <= addr_q + 1'b1;
        idx        <= '0;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] cs_q;
  always_ff @(posedge clk) begin
    if (!rst_n)       cs_q <= '0;
    else if (restart) cs_q <= '0;
    else if (accept)  cs_q <= cs_q ^ in_byte;
  end
  assign checksum = cs_q;
`else
  assign checksum = 8'h00;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a program-level model predicts every write,
// final word count and checksum; a negedge monitor pops expected writes as wr_en appears.
module tb_imem_loader;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        in_byte = 8'h00;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              cpu_stall;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        checksum;
  logic [1:0]        fsm_state;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_byte(in_byte), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .cpu_stall(cpu_stall),
    .word_count(word_count), .checksum(checksum), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [35:0] exp_q[$];
  logic [7:0]  prog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest predicted write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        chk("write_addr_data", {28'h0, wr_addr, wr_data}, {28'h0, exp_q.pop_front()});
        chk("stall_during_write", {62'h0, cpu_stall, busy}, 64'h3);
      end
    end
  end

  // Program-level model: words are consecutive 4-byte groups, MSB first, zero padded, at most DEPTH.
  task automatic model_load(input int max_words, output logic [ADDR_W:0] wc, output logic [7:0] cs);
    int n;
    int words;
    logic [31:0] w_val;
    n = prog.size();
    words = (n + 3) / 4;
    if (words > DEPTH) words = DEPTH;
    if (words > max_words) words = max_words;
    for (int w = 0; w < words; w++) begin
      w_val = 32'h0;
      for (int k = 0; k < 4; k++)
        if (4 * w + k < n) w_val[31 - 8 * k -: 8] = prog[4 * w + k];
      exp_q.push_back({4'(w), w_val});
    end
    wc = (ADDR_W+1)'(words);
    cs = 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
    for (int i = 0; i < n && i < 4 * DEPTH; i++) cs = cs ^ prog[i];
`endif
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input bit gaps);
    int cyc;
    if (gaps) begin
      int g;
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(negedge clk);
        in_valid = 1'b0;
        start = busy && ($urandom_range(0, 2) == 0);
      end
    end
    @(negedge clk);
    start = 1'b0;
    in_byte = b;
    in_last = last;
    in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL byte_accept_timeout: got in_ready 0 expected 1 within 40 cycles");
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic idle_inputs();
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    start = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input bit use_last, input bit gaps, input bit check_first);
    logic [ADDR_W:0] wc;
    logic [7:0] cs;
    int n;
    int cyc;
    n = prog.size();
    pulse_start();
    model_load(DEPTH, wc, cs);
    for (int i = 0; i < n; i++) begin
      send_byte(prog[i], use_last && (i == n - 1), gaps);
      if (check_first && i == 3 && n > 4) begin
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("word_count_after_first_write", 64'(word_count), 64'd1);
      end
    end
    idle_inputs();
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("done", 64'(done), 64'd1);
    chk("busy_stall_cleared", {62'h0, busy, cpu_stall}, 64'h0);
    chk("word_count", 64'(word_count), 64'(wc));
    chk("checksum", 64'(checksum), 64'(cs));
    chk("writes_drained", 64'(exp_q.size()), 64'd0);
    if (wc == (ADDR_W+1)'(DEPTH)) begin
      in_valid = 1'b1;
      in_byte = 8'h5A;
      repeat (4) begin
        @(negedge clk);
        chk("in_ready_low_when_full", 64'(in_ready), 64'd0);
      end
      in_valid = 1'b0;
      chk("word_count_saturated", 64'(word_count), 64'(DEPTH));
    end
  endtask

  task automatic check_all_zero(input string name);
    chk(name, {10'h0, in_ready, wr_en, wr_addr, wr_data, busy, done, cpu_stall, word_count, checksum}, 64'h0);
  endtask

  initial begin
    logic [ADDR_W:0] wc_unused;
    logic [7:0] cs_unused;
    int n;

    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    rst_n = 1'b1;

    // Directed first word, then a short tail ending in in_last.
    prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h11, 8'h22, 8'h33};
    run_load(1'b1, 1'b0, 1'b1);

    // Full store from 64 back-to-back bytes without in_last.
    prog.delete();
    for (int i = 0; i < 64; i++) prog.push_back(8'($urandom_range(0, 255)));
    run_load(1'b0, 1'b0, 1'b0);

    // Partial word closed by in_last.
    prog = '{8'hAC, 8'h09};
    run_load(1'b1, 1'b0, 1'b0);

    // Same first word with valid gaps and stray start pulses.
    prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h99};
    run_load(1'b1, 1'b1, 1'b0);

    // Reset after 2 words plus 2 bytes: only 2 writes may appear.
    prog.delete();
    for (int i = 0; i < 10; i++) prog.push_back(8'($urandom_range(0, 255)));
    pulse_start();
    model_load(2, wc_unused, cs_unused);
    for (int i = 0; i < 10; i++) send_byte(prog[i], 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("mid_load_reset_outputs");
    chk("writes_before_reset", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b1;

    // Checksum pattern; the load restarts from address 0 after the reset.
    prog = '{8'h01, 8'h02, 8'h04, 8'h08};
    run_load(1'b1, 1'b0, 1'b0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("checksum_pattern", 64'(checksum), 64'h0F);
`else
    chk("checksum_pattern", 64'(checksum), 64'h00);
`endif

    // Random programs.
    for (int t = 0; t < 6; t++) begin
      prog.delete();
      n = $urandom_range(1, 64);
      for (int i = 0; i < n; i++) prog.push_back(8'($urandom_range(0, 255)));
      run_load((n < 64) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
